// File: rtl/smg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active-high, bit order {dp,g,f,e,d,c,b,a}.
package smg_pkg;

    localparam int DIGIT_W = 4;
    localparam int DOUT_W  = 16;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/smg_seg_decode.sv
// BCD digit to active-high seven-segment pattern.
// Ports:
//   digit - 4-bit code; 10..15 show a dash
//   dp    - decimal point, drives seg[7]
//   blank - forces seg[6:0] off (dp unaffected)
//   seg   - {dp,g,f,e,d,c,b,a}, 1 = lit
module smg_seg_decode
    import smg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               dp,
    input  logic               blank,
    output logic [7:0]         seg
);

    logic [7:0] seg_num;

    always_comb begin
        seg_num = SEG_OFF;
        case (digit)
            4'd0:    seg_num = SEG_0;
            4'd1:    seg_num = SEG_1;
            4'd2:    seg_num = SEG_2;
            4'd3:    seg_num = SEG_3;
            4'd4:    seg_num = SEG_4;
            4'd5:    seg_num = SEG_5;
            4'd6:    seg_num = SEG_6;
            4'd7:    seg_num = SEG_7;
            4'd8:    seg_num = SEG_8;
            4'd9:    seg_num = SEG_9;
            default: seg_num = SEG_DASH;
        endcase
        seg = {dp, blank ? 7'b0 : seg_num[6:0]};
    end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multi-digit seven-segment scan controller feeding a 74HC595 serializer.
// One {sel, seg} word is produced per scan slot over a valid/ready handshake.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   en                - scan enable (slot timer held at 0 when low)
//   bcd_in, dp_in     - packed digits (digit 0 rightmost) and decimal points
//   blank_lz          - blank leading zeros
//   dout, dout_vld    - {sel[7:0], seg[7:0]} word and its valid
//   dout_rdy          - serializer accepts the word
//   overrun           - one-cycle pulse when a slot tick is dropped
//
// state | meaning
// IDLE  | waiting for a slot tick
// LOAD  | decoding the current digit into dout
// SEND  | dout_vld high, waiting for dout_rdy
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_CNT       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*DIGITS-1:0]     bcd_in,
    input  logic [DIGITS-1:0]       dp_in,
    input  logic                    blank_lz,
    output logic [DOUT_W-1:0]       dout,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic                    overrun
);

    localparam int TMR_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SCAN_CNT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DOUT_W-1:0] DOUT_IDLE = {DOUT_W{SEG_ACTIVE_LOW}};

    state_t                 state;
    logic [TMR_W-1:0]       timer;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic                   tick;
    logic                   hs;
    logic                   take_snap;
    logic [4*DIGITS-1:0]    bcd_s;
    logic [DIGITS-1:0]      dp_s;
    logic                   blz_s;
    logic [DIGITS-1:0]      lz_mask;
    logic                   zero_above;
    logic [DIGIT_W-1:0]     digit_cur;
    logic [7:0]             seg_dec;
    logic [7:0]             sel_raw;
    logic [DOUT_W-1:0]      word_raw;

    assign tick     = en && (timer == TMR_LAST);
    assign hs       = (state == SEND) && dout_vld && dout_rdy;
    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Snapshot only when a tick is actually taken for digit 0, so a dropped
    // tick can never refresh the data halfway through a frame.
    assign take_snap = tick && (((state == IDLE) && (idx == '0)) ||
                                (hs && (idx_next == '0)));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            timer <= '0;
        end else if (timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_s <= '0;
            dp_s  <= '0;
            blz_s <= 1'b0;
        end else if (take_snap) begin
            bcd_s <= bcd_in;
            dp_s  <= dp_in;
            blz_s <= blank_lz;
        end
    end

    // lz_mask[i] = digits DIGITS-1..i of the snapshot are all zero.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (bcd_s[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_above;
        end
        lz_mask[0] = 1'b0;
    end

    assign digit_cur = bcd_s[idx*DIGIT_W +: DIGIT_W];

    smg_seg_decode u_dec (
        .digit (digit_cur),
        .dp    (dp_s[idx]),
        .blank (blz_s && lz_mask[idx]),
        .seg   (seg_dec)
    );

    assign sel_raw  = 8'(1) << idx;
    assign word_raw = {sel_raw, seg_dec};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            dout     <= DOUT_IDLE;
            dout_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) state <= LOAD;
                end
                LOAD: begin
                    dout     <= SEG_ACTIVE_LOW ? ~word_raw : word_raw;
                    dout_vld <= 1'b1;
                    state    <= SEND;
                    if (tick) overrun <= 1'b1;
                end
                SEND: begin
                    if (hs) begin
                        dout_vld <= 1'b0;
                        idx      <= idx_next;
                        state    <= tick ? LOAD : IDLE;
                    end else if (tick) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
module tb_smg_scan_ctrl;

    localparam int PERIOD = 10;
    localparam int DIGITS = 6;
    localparam int SCAN   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [23:0] bcd_in = '0;
    logic [5:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_rdy = 1'b1;
    logic        overrun;

    int compared = 0;
    int mismatched = 0;
    int ov_cnt = 0;
    logic [15:0] exp_q[$];

    smg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_CNT(SCAN), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .overrun(overrun)
    );

    always #(PERIOD/2) clk = ~clk;

    function automatic logic [7:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h40;
        endcase
    endfunction

    function automatic logic [15:0] model_word(input int idx, input logic [23:0] bcd,
                                               input logic [5:0] dp, input logic blz);
        logic [7:0] seg;
        logic [7:0] sel;
        bit all0;
        seg = ref_seg(bcd[idx*4 +: 4]);
        all0 = 1'b1;
        for (int j = idx; j < DIGITS; j++)
            if (bcd[j*4 +: 4] != 4'd0) all0 = 1'b0;
        if (blz && idx != 0 && all0) seg = 8'h00;
        if (dp[idx]) seg[7] = 1'b1;
        sel = 8'h01;
        sel = sel << idx;
        return {~sel, ~seg};
    endfunction

    // Scoreboard: pops an expected word for every accepted handshake.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (overrun) ov_cnt++;
            if (!rst && dout_vld && dout_rdy) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL word_unexpected: got %h, required none", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        mismatched++;
                        $display("FAIL word: got %h, required %h", dout, e);
                    end
                end
            end
        end
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dout_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        dout_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (dout_vld !== 1'b0) begin mismatched++; $display("FAIL reset_vld: got %b, required 0", dout_vld); end
        compared++;
        if (dout !== 16'hFFFF) begin mismatched++; $display("FAIL reset_dout: got %h, required ffff", dout); end
        compared++;
        if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        rst = 1'b0;
    endtask

    // Runs n words with dout_rdy high, checking slot spacing and vld width.
    task automatic run_words(input int n, input int change_at, input logic [23:0] new_bcd);
        bit ok;
        time t_prev;
        t_prev = 0;
        en = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_vld(SCAN + 25, ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL vld_timeout: word %0d not seen, required within %0d clocks", k, SCAN + 25); end
            if (k > 0) begin
                compared++;
                if ($time - t_prev != SCAN * PERIOD) begin
                    mismatched++;
                    $display("FAIL slot_spacing: got %0t, required %0d", $time - t_prev, SCAN * PERIOD);
                end
            end
            t_prev = $time;
            if (k == change_at) bcd_in = new_bcd;
            if (k == n - 1) en = 1'b0;
            @(negedge clk);
            compared++;
            if (dout_vld !== 1'b0) begin mismatched++; $display("FAIL vld_width: got %b, required 0", dout_vld); end
        end
        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL words_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_basic_scan();
        int ov0;
        do_reset();
        bcd_in = 24'h123456; dp_in = '0; blank_lz = 1'b0;
        for (int k = 0; k < DIGITS; k++) exp_q.push_back(model_word(k, bcd_in, dp_in, blank_lz));
        ov0 = ov_cnt;
        run_words(DIGITS, -1, '0);
        compared++;
        if (ov_cnt != ov0) begin mismatched++; $display("FAIL basic_overrun: got %0d, required 0", ov_cnt - ov0); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        logic [15:0] held;
        int ov0;
        do_reset();
        bcd_in = 24'h123456; dp_in = '0; blank_lz = 1'b0;
        dout_rdy = 1'b0;
        exp_q.push_back(model_word(0, bcd_in, dp_in, blank_lz));
        exp_q.push_back(model_word(1, bcd_in, dp_in, blank_lz));
        ov0 = ov_cnt;
        en = 1'b1;
        wait_vld(SCAN + 25, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL bp_first_vld: not seen, required within %0d clocks", SCAN + 25); end
        held = dout;
        stable = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (dout !== held || dout_vld !== 1'b1) stable = 1'b0;
        end
        compared++;
        if (!stable) begin mismatched++; $display("FAIL bp_hold: got dout %h vld %b, required %h and 1", dout, dout_vld, held); end
        compared++;
        if (ov_cnt - ov0 != 2) begin mismatched++; $display("FAIL bp_overruns: got %0d, required 2", ov_cnt - ov0); end
        dout_rdy = 1'b1;
        @(negedge clk);
        compared++;
        if (dout_vld !== 1'b0) begin mismatched++; $display("FAIL bp_accept: got vld %b, required 0", dout_vld); end
        wait_vld(SCAN + 25, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL bp_next_vld: not seen, required within %0d clocks", SCAN + 25); end
        en = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL bp_words_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_blank_lz();
        do_reset();
        bcd_in = 24'h000070; dp_in = 6'b000001; blank_lz = 1'b1;
        for (int k = 0; k < DIGITS; k++) exp_q.push_back(model_word(k, bcd_in, dp_in, blank_lz));
        run_words(DIGITS, -1, '0);
    endtask

    task automatic test_dash_snapshot();
        do_reset();
        bcd_in = 24'hF00000; dp_in = '0; blank_lz = 1'b0;
        for (int k = 0; k < DIGITS; k++) exp_q.push_back(model_word(k, 24'hF00000, dp_in, 1'b0));
        for (int k = 0; k < DIGITS; k++) exp_q.push_back(model_word(k, 24'h000000, dp_in, 1'b0));
        run_words(2 * DIGITS, 3, 24'h000000);
    endtask

    task automatic test_en_rst();
        bit ok;
        bit quiet;
        do_reset();
        bcd_in = 24'h123456; dp_in = '0; blank_lz = 1'b0;
        dout_rdy = 1'b0;
        en = 1'b1;
        wait_vld(SCAN + 25, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL en_first_vld: not seen, required within %0d clocks", SCAN + 25); end
        en = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (dout_vld !== 1'b1) begin mismatched++; $display("FAIL en_pending: got vld %b, required 1", dout_vld); end
        exp_q.push_back(model_word(0, bcd_in, dp_in, blank_lz));
        dout_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (dout_vld !== 1'b0) begin mismatched++; $display("FAIL en_complete: got vld %b, required 0", dout_vld); end
        quiet = 1'b1;
        for (int i = 0; i < 3 * SCAN; i++) begin
            @(negedge clk);
            if (dout_vld) quiet = 1'b0;
        end
        compared++;
        if (!quiet) begin mismatched++; $display("FAIL en_quiet: got vld while en=0, required none"); end
        dout_rdy = 1'b0;
        en = 1'b1;
        wait_vld(SCAN + 25, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL en_resume_vld: not seen, required within %0d clocks", SCAN + 25); end
        compared++;
        if (dout !== model_word(1, bcd_in, dp_in, blank_lz)) begin
            mismatched++;
            $display("FAIL en_resume_word: got %h, required %h", dout, model_word(1, bcd_in, dp_in, blank_lz));
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (dout_vld !== 1'b0) begin mismatched++; $display("FAIL rst_mid_vld: got %b, required 0", dout_vld); end
        compared++;
        if (dout !== 16'hFFFF) begin mismatched++; $display("FAIL rst_mid_dout: got %h, required ffff", dout); end
        rst = 1'b0;
        dout_rdy = 1'b1;
        exp_q.push_back(model_word(0, bcd_in, dp_in, blank_lz));
        wait_vld(SCAN + 25, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rst_restart_vld: not seen, required within %0d clocks", SCAN + 25); end
        en = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL rst_words_left: got %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_blank_lz();
        test_dash_snapshot();
        test_en_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
